// File: rtl/b08_match_scheduler.sv
// b08_match_scheduler: round-robin time-sharing of one b08 match core.
// Grants a requester word, runs the core, returns the tagged 4-bit result.
module b08_match_scheduler #(
  parameter int NREQ      = 4,
  parameter int ID_W      = 2,
  parameter int CORE_LAT  = 12,
  parameter int START_LEN = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              core_start,
  output logic [7:0]        core_in,
  input  logic [3:0]        core_out,
  output logic              rsp_valid,
  output logic [ID_W-1:0]   rsp_id,
  output logic [3:0]        rsp_data,
  input  logic              rsp_ready,
  output logic              busy
);

  localparam int CW = $clog2(CORE_LAT + 1);
  localparam logic [ID_W:0] NR = (ID_W+1)'(NREQ);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_WAIT,
    S_CAPT,
    S_RESP
  } state_t;

  state_t          state;
  logic [ID_W-1:0] rr_ptr;
  logic [ID_W-1:0] cur_id;
  logic [ID_W-1:0] gnt_id;
  logic [ID_W-1:0] nxt_ptr;
  logic [ID_W:0]   sum;
  logic [ID_W:0]   inc;
  logic [CW-1:0]   cnt;
  logic            gnt_any;

  // Round-robin search: first valid requester at or after rr_ptr.
  always_comb begin
    gnt_any = 1'b0;
    gnt_id  = '0;
    sum     = '0;
    for (int k = 0; k < NREQ; k++) begin
      sum = {1'b0, rr_ptr} + (ID_W+1)'(k);
      if (sum >= NR) sum = sum - NR;
      if (!gnt_any && req_valid[sum[ID_W-1:0]]) begin
        gnt_any = 1'b1;
        gnt_id  = sum[ID_W-1:0];
      end
    end
  end

  // Pointer moves just past the winner, wrapping at NREQ.
  always_comb begin
    inc = {1'b0, gnt_id} + (ID_W+1)'(1);
    if (inc >= NR) inc = '0;
    nxt_ptr = inc[ID_W-1:0];
  end

  // Accept is only offered from IDLE and never while held in reset.
  assign req_ready = (state == S_IDLE && gnt_any && reset_n)
                   ? (NREQ'(1) << gnt_id) : '0;

  assign busy = (state != S_IDLE);

  // Job sequencer: grant, START pulse, latency wait, capture, respond.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state      <= S_IDLE;
      rr_ptr     <= '0;
      cur_id     <= '0;
      cnt        <= '0;
      core_start <= 1'b0;
      core_in    <= '0;
      rsp_valid  <= 1'b0;
      rsp_id     <= '0;
      rsp_data   <= '0;
    end else begin
      unique case (state)
        S_IDLE: begin
          if (gnt_any) begin
            core_in    <= req_data[8*gnt_id +: 8];
            cur_id     <= gnt_id;
            rr_ptr     <= nxt_ptr;
            cnt        <= '0;
            core_start <= 1'b1;
            state      <= S_START;
          end
        end
        S_START: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(START_LEN - 1)) begin
            core_start <= 1'b0;
            state      <= S_WAIT;
          end
        end
        S_WAIT: begin
          cnt <= cnt + CW'(1);
          if (cnt == CW'(CORE_LAT - 1)) state <= S_CAPT;
        end
        S_CAPT: begin
          rsp_data  <= core_out;
          rsp_id    <= cur_id;
          rsp_valid <= 1'b1;
          state     <= S_RESP;
        end
        S_RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_b08_match_scheduler.sv
// tb_b08_match_scheduler: directed scenarios plus random traffic,
// checked each cycle against a job-timeline model of the scheduler.
module tb_b08_match_scheduler;

  localparam int NREQ = 4;
  localparam int ID_W = 2;
  localparam int LAT  = 12;
  localparam int SLEN = 2;

  logic              clock = 1'b0;
  logic              reset_n = 1'b0;
  logic [NREQ-1:0]   req_valid = '0;
  logic [8*NREQ-1:0] req_data = '0;
  logic [NREQ-1:0]   req_ready;
  logic              core_start;
  logic [7:0]        core_in;
  logic [3:0]        core_out = '0;
  logic              rsp_valid;
  logic [ID_W-1:0]   rsp_id;
  logic [3:0]        rsp_data;
  logic              rsp_ready = 1'b0;
  logic              busy;

  logic [NREQ-1:0]   s_req_valid = '0;
  logic [8*NREQ-1:0] s_req_data = '0;
  logic [NREQ-1:0]   s_req_ready;
  logic              s_core_start;
  logic [7:0]        s_core_in;
  logic [3:0]        s_core_out = '0;
  logic              s_rsp_valid;
  logic [ID_W-1:0]   s_rsp_id;
  logic [3:0]        s_rsp_data;
  logic              s_rsp_ready = 1'b0;
  logic              s_busy;

  int checks = 0;
  int errors = 0;

  always #5 clock = ~clock;

  b08_match_scheduler #(
    .NREQ(NREQ), .ID_W(ID_W), .CORE_LAT(LAT), .START_LEN(SLEN)
  ) u_dut (
    .clock(clock), .reset_n(reset_n),
    .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .core_start(core_start),
    .core_in(core_in), .core_out(core_out),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id),
    .rsp_data(rsp_data), .rsp_ready(rsp_ready),
    .busy(busy)
  );

  b08_match_scheduler #(
    .NREQ(NREQ), .ID_W(ID_W), .CORE_LAT(4), .START_LEN(1)
  ) u_short (
    .clock(clock), .reset_n(reset_n),
    .req_valid(s_req_valid), .req_data(s_req_data),
    .req_ready(s_req_ready), .core_start(s_core_start),
    .core_in(s_core_in), .core_out(s_core_out),
    .rsp_valid(s_rsp_valid), .rsp_id(s_rsp_id),
    .rsp_data(s_rsp_data), .rsp_ready(s_rsp_ready),
    .busy(s_busy)
  );

  function automatic void chk(string nm, logic [31:0] act,
                              logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", nm, act, exp);
    end
  endfunction

  function automatic int oh2i(logic [NREQ-1:0] v);
    for (int i = 0; i < NREQ; i++) if (v[i]) return i;
    return -1;
  endfunction

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Job-timeline model: n counts cycles since the grant cycle.
  bit              m_idle = 1'b1;
  int              m_rr = 0;
  int              m_n = 0;
  int              m_id = 0;
  logic [7:0]      m_core_in = '0;
  logic [3:0]      m_cap = '0;
  logic [NREQ-1:0] m_gnt = '0;

  initial forever begin
    @(negedge clock);
    if (!reset_n) begin
      chk("rst_ready", req_ready, 0);
      chk("rst_start", core_start, 0);
      chk("rst_core_in", core_in, 0);
      chk("rst_rsp_valid", rsp_valid, 0);
      chk("rst_rsp_id", rsp_id, 0);
      chk("rst_rsp_data", rsp_data, 0);
      chk("rst_busy", busy, 0);
      m_idle = 1'b1;
      m_rr = 0;
      m_core_in = '0;
      m_gnt = '0;
    end else if (m_idle) begin
      int g;
      g = -1;
      for (int k = 0; k < NREQ; k++)
        if (g < 0 && req_valid[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
      m_gnt = '0;
      if (g >= 0) m_gnt[g] = 1'b1;
      chk("m_ready", req_ready, m_gnt);
      chk("m_idle_busy", busy, 0);
      chk("m_idle_start", core_start, 0);
      chk("m_idle_rsp_valid", rsp_valid, 0);
      chk("m_core_in", core_in, m_core_in);
      if (g >= 0) begin
        m_idle = 1'b0;
        m_n = 1;
        m_id = g;
        m_core_in = req_data[8*g +: 8];
        m_rr = (g + 1) % NREQ;
      end
    end else begin
      m_gnt = '0;
      chk("m_ready_busy", req_ready, 0);
      chk("m_busy", busy, 1);
      chk("m_start", core_start, 32'(m_n <= SLEN));
      chk("m_core_in", core_in, m_core_in);
      chk("m_rsp_valid", rsp_valid, 32'(m_n >= LAT + 2));
      if (m_n == LAT + 1) m_cap = core_out;
      if (m_n >= LAT + 2) begin
        chk("m_rsp_id", rsp_id, m_id);
        chk("m_rsp_data", rsp_data, m_cap);
        if (rsp_ready) m_idle = 1'b1;
        else m_n++;
      end else begin
        m_n++;
      end
    end
  end

  task automatic wait_grant(output int g);
    g = -1;
    for (int i = 0; i < 300; i++) begin
      @(negedge clock);
      if (req_ready != 0) begin
        g = oh2i(req_ready);
        return;
      end
      step();
    end
    checks++;
    errors++;
    $display("FAIL grant_timeout act=none exp=grant");
  endtask

  task automatic wait_rsp();
    for (int i = 0; i < 300; i++) begin
      step();
      @(negedge clock);
      if (rsp_valid) return;
    end
    checks++;
    errors++;
    $display("FAIL rsp_timeout act=none exp=rsp_valid");
  endtask

  task automatic handshake();
    step();
    rsp_ready = 1'b1;
    step();
    rsp_ready = 1'b0;
  endtask

  initial begin
    int g;
    int gq[$];
    int rq[$];
    int exp4[3];
    exp4 = '{3, 0, 3};

    repeat (3) @(posedge clock);
    #1;
    reset_n = 1'b1;

    // Test 1: single job, exact timing.
    req_valid = 4'b0001;
    req_data[7:0] = 8'hA5;
    core_out = 4'h9;
    @(negedge clock);
    chk("t1_grant", req_ready, 4'b0001);
    for (int c = 1; c <= 14; c++) begin
      step();
      if (c == 1) req_valid = '0;
      @(negedge clock);
      chk("t1_start", core_start, 32'(c <= 2));
      chk("t1_rsp_valid", rsp_valid, 32'(c == 14));
    end
    chk("t1_id", rsp_id, 0);
    chk("t1_data", rsp_data, 4'h9);
    chk("t1_core_in", core_in, 8'hA5);
    handshake();

    // Test 3: backpressure; rr_ptr is 1 here.
    req_valid = 4'b0110;
    req_data[15:8] = 8'h77;
    req_data[23:16] = 8'h88;
    core_out = 4'hC;
    wait_grant(g);
    chk("t3_grant", g, 1);
    step();
    req_valid = 4'b0100;
    wait_rsp();
    chk("t3_id", rsp_id, 1);
    chk("t3_data", rsp_data, 4'hC);
    for (int c = 0; c < 20; c++) begin
      step();
      core_out = 4'($urandom);
      @(negedge clock);
      chk("t3_hold_valid", rsp_valid, 1);
      chk("t3_hold_id", rsp_id, 1);
      chk("t3_hold_data", rsp_data, 4'hC);
      chk("t3_hold_start", core_start, 0);
      chk("t3_hold_ready", req_ready, 0);
    end
    handshake();
    wait_grant(g);
    chk("t3_next_grant", g, 2);
    step();
    req_valid = '0;
    wait_rsp();
    handshake();

    // Test 4: wrap fairness from rr_ptr 3.
    req_valid = 4'b1001;
    for (int j = 0; j < 3; j++) begin
      wait_grant(g);
      chk("t4_grant", g, exp4[j]);
      wait_rsp();
      handshake();
    end
    req_valid = '0;

    // Test 2: all requesters valid, consumer always ready.
    for (int i = 0; i < NREQ; i++) req_data[8*i +: 8] = 8'(8'h10 + i);
    req_valid = 4'b1111;
    rsp_ready = 1'b1;
    for (int c = 0; c < 200; c++) begin
      @(negedge clock);
      if (req_ready != 0) gq.push_back(oh2i(req_ready));
      if (rsp_valid) rq.push_back(int'(rsp_id));
      if (rq.size() >= 5) break;
      step();
    end
    step();
    req_valid = '0;
    rsp_ready = 1'b0;
    chk("t2_ngrant", gq.size(), 5);
    chk("t2_nrsp", rq.size(), 5);
    for (int j = 0; j < 5 && j < gq.size() && j < rq.size(); j++) begin
      chk("t2_grant_order", gq[j], j % 4);
      chk("t2_rsp_order", rq[j], j % 4);
    end

    // Test 5: reset in WAIT; rr_ptr is 1 here.
    req_valid = 4'b1010;
    req_data[15:8] = 8'h5A;
    wait_grant(g);
    chk("t5_grant", g, 1);
    repeat (6) step();
    reset_n = 1'b0;
    @(negedge clock);
    chk("t5_rst_start", core_start, 0);
    chk("t5_rst_busy", busy, 0);
    chk("t5_rst_core_in", core_in, 0);
    step();
    step();
    reset_n = 1'b1;
    wait_grant(g);
    chk("t5_regrant", g, 1);
    step();
    req_valid = 4'b1000;
    wait_rsp();
    chk("t5_id", rsp_id, 1);
    handshake();
    req_valid = '0;

    // Test 6: short-latency build, capture exactly at CAPT.
    s_req_valid = 4'b0001;
    s_req_data[7:0] = 8'h3C;
    s_core_out = 4'h5;
    @(negedge clock);
    chk("t6_grant", s_req_ready, 4'b0001);
    for (int c = 1; c <= 6; c++) begin
      step();
      if (c == 1) s_req_valid = '0;
      if (c == 6) s_core_out = 4'hA;
      @(negedge clock);
      chk("t6_start", s_core_start, 32'(c == 1));
      chk("t6_rsp_valid", s_rsp_valid, 32'(c == 6));
    end
    chk("t6_data", s_rsp_data, 4'h5);
    chk("t6_id", s_rsp_id, 0);
    chk("t6_core_in", s_core_in, 8'h3C);
    step();
    s_rsp_ready = 1'b1;
    step();
    s_rsp_ready = 1'b0;
    @(negedge clock);
    chk("t6_done_valid", s_rsp_valid, 0);
    chk("t6_done_busy", s_busy, 0);

    // Random traffic: requesters hold valid until granted.
    for (int c = 0; c < 3000; c++) begin
      step();
      for (int i = 0; i < NREQ; i++) begin
        if (m_gnt[i]) req_valid[i] = 1'b0;
        if (!req_valid[i] && $urandom_range(0, 5) == 0) begin
          req_valid[i] = 1'b1;
          req_data[8*i +: 8] = 8'($urandom);
        end
      end
      core_out = 4'($urandom);
      rsp_ready = 1'($urandom_range(0, 1));
    end
    step();
    req_valid = '0;
    rsp_ready = 1'b1;
    repeat (40) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
